multi_channel_emissions_monitor: RTL

//   Parametrised successor to the single-sensor emissions FSM. Monitors NUM_CH gas/sensor

---
 rtl/emissions_pkg.sv | 15 +
 rtl/emissions_channel_fsm.sv | 140 ++++++++++++++
 rtl/multi_channel_emissions_monitor.sv | 63 ++++++
 3 files changed

// File: rtl/emissions_pkg.sv
// Shared types for the multi-channel emissions monitor.
// Channel grade values double as the sample class so the two can be compared directly.
package emissions_pkg;

  typedef enum logic [1:0] {
    ST_NORMAL   = 2'd0,
    ST_WARNING  = 2'd1,
    ST_CRITICAL = 2'd2
  } ch_state_e;

  function automatic logic is_critical(input ch_state_e s);
    return (s == ST_CRITICAL);
  endfunction

endpackage

// File: rtl/emissions_channel_fsm.sv
// One emissions channel: classifier, persistence counters, hysteresis, acknowledged critical latch.
// Outputs are flops loaded from the next-state decode so they move on the deciding edge.
module emissions_channel_fsm
  import emissions_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int WARN_TH    = 50,
  parameter int CRIT_TH    = 100,
  parameter int HYST       = 5,
  parameter int PERSIST    = 3,
  parameter int LATCH_CRIT = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sample_valid,
  input  logic [WIDTH-1:0] level,
  input  logic             alarm_ack,
  output logic             warning,
  output logic             critical,
  output logic             state_change
);

  localparam int CW = $clog2(PERSIST + 1);
  localparam logic [CW-1:0] PERSIST_M1 = CW'(PERSIST - 1);
  localparam logic [CW-1:0] PERSIST_C  = CW'(PERSIST);
  localparam logic [WIDTH-1:0] WARN_T  = WIDTH'(WARN_TH);
  localparam logic [WIDTH-1:0] CRIT_T  = WIDTH'(CRIT_TH);
  localparam logic [WIDTH-1:0] WARN_LO = WIDTH'(WARN_TH - HYST);
  localparam logic [WIDTH-1:0] CRIT_LO = WIDTH'(CRIT_TH - HYST);

  ch_state_e     state, state_n;
  logic [CW-1:0] up_cnt, up_n;
  logic [CW-1:0] dn_cnt, dn_n;
  logic          ack_seen, ack_n;
  logic          change_n;

  ch_state_e     cls;
  ch_state_e     dn_target;
  logic          up_q;
  logic          dn_q;
  logic          ack_eff;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_NORMAL;
      up_cnt       <= '0;
      dn_cnt       <= '0;
      ack_seen     <= 1'b0;
      warning      <= 1'b0;
      critical     <= 1'b0;
      state_change <= 1'b0;
    end else begin
      state        <= state_n;
      up_cnt       <= up_n;
      dn_cnt       <= dn_n;
      ack_seen     <= ack_n;
      warning      <= (state_n == ST_WARNING);
      critical     <= (state_n == ST_CRITICAL);
      state_change <= change_n;
    end
  end

  // Classification and down-path qualification share the hysteresis thresholds.
  always_comb begin
    cls = ST_NORMAL;
    if (level >= CRIT_T) begin
      cls = ST_CRITICAL;
    end else if (level >= WARN_T) begin
      cls = ST_WARNING;
    end

    up_q      = (cls > state);
    dn_q      = 1'b0;
    dn_target = ST_NORMAL;
    case (state)
      ST_WARNING: begin
        dn_q = (level < WARN_LO);
      end
      ST_CRITICAL: begin
        dn_q      = (level < CRIT_LO);
        dn_target = (level < WARN_LO) ? ST_NORMAL : ST_WARNING;
      end
      default: begin
        dn_q = 1'b0;
      end
    endcase

    ack_eff = ack_seen | (alarm_ack & is_critical(state));
  end

  always_comb begin
    state_n  = state;
    up_n     = up_cnt;
    dn_n     = dn_cnt;
    ack_n    = ack_seen;
    change_n = 1'b0;

    if (is_critical(state) && alarm_ack) begin
      ack_n = 1'b1;
    end

    if (sample_valid) begin
      if (up_q) begin
        dn_n = '0;
        if (up_cnt == PERSIST_M1) begin
          state_n  = cls;
          up_n     = '0;
          change_n = 1'b1;
          if (cls == ST_CRITICAL) begin
            ack_n = 1'b0;
          end
        end else begin
          up_n = up_cnt + CW'(1);
        end
      end else if (dn_q) begin
        up_n = '0;
        // A latched critical waits for an ack; its counter saturates meanwhile.
        if ((LATCH_CRIT != 0) && is_critical(state)) begin
          if ((dn_cnt >= PERSIST_M1) && ack_eff) begin
            state_n  = dn_target;
            dn_n     = '0;
            change_n = 1'b1;
          end else if (dn_cnt < PERSIST_C) begin
            dn_n = dn_cnt + CW'(1);
          end
        end else if (dn_cnt == PERSIST_M1) begin
          state_n  = dn_target;
          dn_n     = '0;
          change_n = 1'b1;
        end else begin
          dn_n = dn_cnt + CW'(1);
        end
      end else begin
        up_n = '0;
        dn_n = '0;
      end
    end
  end

endmodule

// File: rtl/multi_channel_emissions_monitor.sv
// NUM_CH independent emissions channels graded NORMAL / WARNING / CRITICAL.
// Only slicing, per-channel instances and summary ORs live here.
module multi_channel_emissions_monitor
  import emissions_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int NUM_CH     = 4,
  parameter int WARN_TH    = 50,
  parameter int CRIT_TH    = 100,
  parameter int HYST       = 5,
  parameter int PERSIST    = 3,
  parameter int LATCH_CRIT = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    sample_valid,
  input  logic [NUM_CH*WIDTH-1:0] level,
  input  logic [NUM_CH-1:0]       alarm_ack,
  output logic [NUM_CH-1:0]       warning,
  output logic [NUM_CH-1:0]       critical,
  output logic [NUM_CH-1:0]       state_change,
  output logic                    any_warning,
  output logic                    any_critical
);

  // Reject threshold sets that would break the classifier or the counters.
  if (WARN_TH >= CRIT_TH) begin : g_bad_order
    $error("WARN_TH must be below CRIT_TH");
  end
  if (HYST > WARN_TH) begin : g_bad_hyst
    $error("HYST must not exceed WARN_TH");
  end
  if (PERSIST == 0) begin : g_bad_persist
    $error("PERSIST must be at least 1");
  end
  if (CRIT_TH >= (1 << WIDTH)) begin : g_bad_range
    $error("CRIT_TH does not fit in WIDTH bits");
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    emissions_channel_fsm #(
      .WIDTH      (WIDTH),
      .WARN_TH    (WARN_TH),
      .CRIT_TH    (CRIT_TH),
      .HYST       (HYST),
      .PERSIST    (PERSIST),
      .LATCH_CRIT (LATCH_CRIT)
    ) u_ch (
      .clk          (clk),
      .reset        (reset),
      .sample_valid (sample_valid),
      .level        (level[i*WIDTH +: WIDTH]),
      .alarm_ack    (alarm_ack[i]),
      .warning      (warning[i]),
      .critical     (critical[i]),
      .state_change (state_change[i])
    );
  end

  assign any_warning  = |warning;
  assign any_critical = |critical;

endmodule
